ram_access_ctrl: RTL and testbench

- Load/store front end that sits directly upstream of the 32-bit word RAM (7-bit word address, bidirectional data bus, level-sensitive write enable).
- Accepts byte/halfword/word requests from the core through a req/ready handshake.
- Aligns, sign- or zero-extends load data; performs read-modify-write for sub-word stores.
- Owns the RAM tristate bus turnaround; flags misaligned and illegal accesses without touching the RAM.

---
 rtl/ram_access_ctrl.sv | 129 ++++++++++++
 tb/tb_ram_access_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// Load/store front end for a 32-bit word RAM: aligns and extends loads,
// does read-modify-write for sub-word stores and owns the bus turnaround.
module ram_access_ctrl #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [31:0]       ram_data,
  output logic              ram_wre
);

  typedef enum logic [2:0] {IDLE, RD, WR, TURN, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state, state_nxt;
  logic              we_q, signed_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wword_q, rdata_q;
  logic              req_bad;

  function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'b11) || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a != 2'b00);
  endfunction

  // Lanes are aligned, so a byte-granular shift serves both byte and halfword.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                              input logic sgn, input logic [1:0] a);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (sz)
      SZ_BYTE: return {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] mask;
    mask = (sz == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
    return (old_w & ~(mask << {a, 3'b000})) | ((wd & mask) << {a, 3'b000});
  endfunction

  assign req_bad = is_illegal(req_size, req_addr[1:0]);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_bad)                             state_nxt = DONE;
          else if (!req_we || req_size != SZ_WORD) state_nxt = RD;
          else                                     state_nxt = WR;
        end
      end
      RD:      state_nxt = we_q ? WR : DONE;
      WR:      state_nxt = TURN;
      TURN:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wword_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wword_q  <= req_wdata;
            err_q    <= req_bad;
            rdata_q  <= '0;
          end
        end
        RD: begin
          if (we_q) wword_q <= store_merge(ram_data, wword_q, size_q, addr_q[1:0]);
          else      rdata_q <= load_extend(ram_data, size_q, signed_q, addr_q[1:0]);
        end
        default: ;
      endcase
    end
  end

  // Bus drive and write enable come straight from the state register, so the
  // asynchronous reset releases them without waiting for a clock edge.
  assign ram_data   = (state == WR || state == TURN) ? wword_q : 'z;
  assign ram_wre    = (state == WR);
  assign ram_addr   = addr_q[ADDR_W+1:2];
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: a RAM model on a pulled-up bus and
// a byte-lane reference model predict data, latency, bus drive and write pulses.
module tb_ram_access_ctrl;
  localparam int ADDR_W = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  wire         req_ready, resp_valid, resp_err, ram_wre;
  wire  [31:0] resp_rdata;
  wire  [6:0]  ram_addr;
  tri1  [31:0] ram_data;

  ram_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wre(ram_wre)
  );

  always #5 clk = ~clk;

  // RAM model: drives the bus only when the bench opens its read window, and
  // writes while wre is high (sampled mid-cycle).
  logic [31:0] mem [128];
  logic [31:0] model_mem [128];
  logic        ram_oe = 1'b0, pre_en = 1'b0, clr = 1'b1;
  logic [6:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] last_rdata;

  assign ram_data = ram_oe ? mem[ram_addr] : 32'bz;

  always @(negedge clk) begin
    if (clr)          for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
    else if (ram_wre) mem[ram_addr] <= ram_data;
    else if (pre_en)  mem[pre_addr] <= pre_data;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_bad(input logic [1:0] sz, input int a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_load(input int a, input logic [1:0] sz, input bit sgn);
    logic [31:0] w, v;
    w = model_mem[a / 4];
    v = w >> (8 * (a % 4));
    case (sz)
      2'd0:    begin v = v & 32'hFF;   if (sgn && v[7])  v = v | 32'hFFFF_FF00; end
      2'd1:    begin v = v & 32'hFFFF; if (sgn && v[15]) v = v | 32'hFFFF_0000; end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(input int a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    int n, off;
    w   = model_mem[a / 4];
    off = a % 4;
    n   = 1 << sz;
    for (int k = 0; k < n; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
    return w;
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    pre_addr = idx[6:0];
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    #1 pre_en = 1'b0;
    model_mem[idx] = d;
  endtask

  // One request end to end; cycle c=1 is the cycle right after the accept edge.
  task automatic do_txn(input bit we, input logic [1:0] sz, input bit sgn,
                        input int a, input logic [31:0] wd, input string tag);
    bit          bad, rd_cycle;
    int          exp_lat, wr_c, lat, w, idx;
    logic [31:0] exp_rdata, exp_bus, exp_drive;
    bad      = model_bad(sz, a);
    idx      = a / 4;
    exp_lat  = bad ? 1 : (!we ? 2 : (sz == 2'd2 ? 3 : 4));
    rd_cycle = !bad && (!we || sz != 2'd2);
    wr_c     = (bad || !we) ? 0 : (sz == 2'd2 ? 1 : 2);
    exp_bus  = (!bad && we) ? model_store(a, sz, wd) : 32'h0;
    exp_rdata = (!bad && !we) ? model_load(a, sz, sgn) : 32'h0;

    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    check({tag, " ready_before"}, req_ready, 1'b1);
    req_we = we; req_size = sz; req_signed = sgn; req_addr = a[8:0]; req_wdata = wd;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      ram_oe = rd_cycle && (c == 1);
      #1;
      check({tag, " busy_ready"}, req_ready, 1'b0);
      check({tag, " wre"}, ram_wre, (c == wr_c));
      check({tag, " ram_addr"}, ram_addr, idx);
      if (!ram_oe) begin
        exp_drive = (wr_c != 0 && (c == wr_c || c == wr_c + 1)) ? exp_bus : 32'hFFFF_FFFF;
        check({tag, " bus"}, ram_data, exp_drive);
      end
      if (resp_valid === 1'b1) begin lat = c; break; end
      @(posedge clk); #1;
    end
    ram_oe = 1'b0;
    last_rdata = resp_rdata;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " err"}, resp_err, bad);
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    @(posedge clk); #2;
    check({tag, " valid_pulse"}, resp_valid, 1'b0);
    check({tag, " ready_after"}, req_ready, 1'b1);
    if (!bad && we) model_mem[idx] = exp_bus;
    check({tag, " ram_word"}, mem[idx], model_mem[idx]);
  endtask

  initial begin
    int acc, resp;
    bit prev_ready;
    logic [31:0] exp_w;
    for (int i = 0; i < 128; i++) model_mem[i] = 32'h0;

    // Reset state
    @(posedge clk); @(posedge clk); #2;
    check("rst ready", req_ready, 1'b1);
    check("rst valid", resp_valid, 1'b0);
    check("rst err", resp_err, 1'b0);
    check("rst rdata", resp_rdata, 32'h0);
    check("rst ram_addr", ram_addr, 7'h0);
    check("rst wre", ram_wre, 1'b0);
    check("rst bus", ram_data, 32'hFFFF_FFFF);
    clr = 1'b0;
    rst = 1'b0;
    @(posedge clk); #2;

    // Word store then load
    do_txn(1'b1, 2'd2, 1'b0, 'h000, 32'hBBBB_BBBB, "st_w0");
    do_txn(1'b1, 2'd2, 1'b0, 'h004, 32'hAAAA_AAAA, "st_w1");
    do_txn(1'b0, 2'd2, 1'b0, 'h000, 32'h0, "ld_w0");
    check("ld_w0 const", last_rdata, 32'hBBBB_BBBB);

    // Sub-word store merge
    preload(5, 32'h1122_3344);
    do_txn(1'b1, 2'd0, 1'b0, 'h016, 32'h0000_00EE, "st_b");
    check("st_b const", mem[5], 32'h11EE_3344);
    do_txn(1'b1, 2'd1, 1'b0, 'h014, 32'h0000_BEEF, "st_h");
    check("st_h const", mem[5], 32'h11EE_BEEF);

    // Load extension
    preload(6, 32'h80FF_7F01);
    do_txn(1'b0, 2'd0, 1'b1, 'h019, 32'h0, "ld_sb1");
    check("ld_sb1 const", last_rdata, 32'h0000_007F);
    do_txn(1'b0, 2'd0, 1'b1, 'h01A, 32'h0, "ld_sb2");
    check("ld_sb2 const", last_rdata, 32'hFFFF_FFFF);
    do_txn(1'b0, 2'd1, 1'b0, 'h01A, 32'h0, "ld_uh2");
    check("ld_uh2 const", last_rdata, 32'h0000_80FF);
    do_txn(1'b0, 2'd1, 1'b1, 'h01A, 32'h0, "ld_sh2");
    check("ld_sh2 const", last_rdata, 32'hFFFF_80FF);

    // Misaligned and illegal accesses
    do_txn(1'b0, 2'd2, 1'b0, 'h002, 32'h0, "err_ldw");
    do_txn(1'b1, 2'd1, 1'b0, 'h001, 32'h1234_5678, "err_sth");
    do_txn(1'b1, 2'd3, 1'b0, 'h008, 32'hDEAD_BEEF, "err_sz3");
    check("err mem0", mem[0], 32'hBBBB_BBBB);

    // Handshake with req held high: one accept per completed load
    exp_w = model_load('h018, 2'd2, 1'b0);
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 9'h018;
    req = 1'b1;
    acc = 0; resp = 0; prev_ready = 1'b0;
    for (int cyc = 0; cyc < 60 && resp < 10; cyc++) begin
      if (req_ready === 1'b1) begin
        check("hs ready_gap", prev_ready, 1'b0);
        acc++;
      end
      if (resp_valid === 1'b1) begin
        check("hs rdata", resp_rdata, exp_w);
        resp++;
      end
      prev_ready = (req_ready === 1'b1);
      if (resp == 10) req = 1'b0;
      @(posedge clk); #1;
      ram_oe = prev_ready;
      #1;
    end
    req = 1'b0;
    ram_oe = 1'b0;
    check("hs accepts", acc, 10);
    check("hs responses", resp, 10);
    @(posedge clk); #2;

    // Reset during the WR cycle of a word store
    preload(4, 32'hCAFE_F00D);
    @(posedge clk); #2;
    req_we = 1'b1; req_size = 2'd2; req_addr = 9'h010; req_wdata = 32'h1234_5678;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    check("rst_mid wre_before", ram_wre, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid wre", ram_wre, 1'b0);
    check("rst_mid bus", ram_data, 32'hFFFF_FFFF);
    check("rst_mid valid", resp_valid, 1'b0);
    check("rst_mid ready", req_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      check("rst_mid no_resp", resp_valid, 1'b0);
    end
    rst = 1'b0;
    @(posedge clk); #2;
    check("rst_mid ready_after", req_ready, 1'b1);
    do_txn(1'b0, 2'd2, 1'b0, 'h010, 32'h0, "rst_mid ld");
    check("rst_mid ld const", last_rdata, 32'hCAFE_F00D);

    // Randomized mix against the reference model
    for (int t = 0; t < 60; t++) begin
      logic [1:0] sz;
      bit we, sgn;
      int a;
      we  = $urandom_range(0, 1);
      sgn = $urandom_range(0, 1);
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom_range(0, 63);
      do_txn(we, sz, sgn, a, $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
